// File: rtl/packer_pkg.sv
// Shared widths, accumulator state and output payload for the byte packer.
package packer_pkg;

   localparam int unsigned BYTE_W             = 8;
   localparam int unsigned WORD_BYTES         = 4;
   localparam int unsigned WORD_W             = BYTE_W * WORD_BYTES;
   localparam int unsigned CNT_W              = 3;
   localparam int unsigned DROP_W             = 8;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 8;

   // Accumulator occupancy: EMPTY = 0 bytes, PARTIAL = 1..3, FULL = 4
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } acc_state_t;

   // Output register payload: packed word plus its valid byte count
   typedef struct packed {
      logic [CNT_W-1:0]  bytes;
      logic [WORD_W-1:0] data;
   } out_word_t;

   // Map a byte count onto the accumulator state
   function automatic acc_state_t acc_state(input logic [CNT_W-1:0] cnt);
      acc_state_t st;
      if (cnt == '0) begin
         st = EMPTY;
      end else if (cnt >= CNT_W'(WORD_BYTES)) begin
         st = FULL;
      end else begin
         st = PARTIAL;
      end
      return st;
   endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle counter for the packer: raises a flush request once a partial word
// has seen TIMEOUT_CYCLES consecutive cycles without a new byte.
module packer_idle_timer
   import packer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_in_valid,
   input  logic i_partial,
   output logic o_flush_c
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [IDLE_W-1:0] r_idle;

   // Count idle cycles while partial; saturate so a blocked flush keeps waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle <= '0;
      end else if (i_in_valid || !i_partial) begin
         r_idle <= '0;
      end else if (r_idle != IDLE_W'(TIMEOUT_CYCLES)) begin
         r_idle <= r_idle + IDLE_W'(1);
      end
   end

   assign o_flush_c = (r_idle == IDLE_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/arb_byte_packer.sv
// Packs bytes from the round-robin arbiter into little-endian 32-bit words
// with a valid/ready output, a one-word holding register and drop tracking.
// Optional idle flush of partial words: define PACKER_TIMEOUT_EN.
module arb_byte_packer
   import packer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic [WORD_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_bytes,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              clr_ovf,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);

   out_word_t         r_out;
   logic              r_out_valid;
   logic [WORD_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_acc_cnt;
   logic              r_ovf;
   logic [DROP_W-1:0] r_drop_cnt;

   acc_state_t        w_state;
   logic              w_out_free;
   logic              w_drop;
   logic              w_flush;
   logic [1:0]        w_lane;

   // Reject a zero timeout at elaboration
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("arb_byte_packer: TIMEOUT_CYCLES must be nonzero");
   end

   assign w_state    = acc_state(r_acc_cnt);
   assign w_out_free = !r_out_valid || out_ready;
   assign w_drop     = in_valid && (w_state == FULL) && !w_out_free;
   assign w_lane     = r_acc_cnt[1:0];

`ifdef PACKER_TIMEOUT_EN
   packer_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_in_valid (in_valid),
      .i_partial  (w_state == PARTIAL),
      .o_flush_c  (w_flush)
   );
`else
   // Without the idle flush a partial word waits for its remaining bytes
   assign w_flush = 1'b0;
`endif

   // Accumulator and output register; unused accumulator lanes stay zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_acc_cnt   <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         unique case (w_state)
            FULL: begin
               if (w_out_free) begin
                  r_out       <= '{bytes: CNT_W'(WORD_BYTES), data: r_acc};
                  r_out_valid <= 1'b1;
                  if (in_valid) begin
                     r_acc     <= WORD_W'(in_data);
                     r_acc_cnt <= CNT_W'(1);
                  end else begin
                     r_acc     <= '0;
                     r_acc_cnt <= '0;
                  end
               end
            end
            EMPTY, PARTIAL: begin
               if (in_valid) begin
                  if (r_acc_cnt == CNT_W'(WORD_BYTES - 1)) begin
                     if (w_out_free) begin
                        r_out       <= '{bytes: CNT_W'(WORD_BYTES),
                                         data:  {in_data, r_acc[WORD_W-BYTE_W-1:0]}};
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_acc_cnt   <= '0;
                     end else begin
                        r_acc[WORD_W-1 -: BYTE_W] <= in_data;
                        r_acc_cnt                 <= CNT_W'(WORD_BYTES);
                     end
                  end else begin
                     r_acc[{w_lane, 3'b000} +: BYTE_W] <= in_data;
                     r_acc_cnt                         <= r_acc_cnt + CNT_W'(1);
                  end
               end else if (w_flush && w_out_free && (w_state == PARTIAL)) begin
                  r_out       <= '{bytes: r_acc_cnt, data: r_acc};
                  r_out_valid <= 1'b1;
                  r_acc       <= '0;
                  r_acc_cnt   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky overflow and saturating drop count; a clear does not hide a same-cycle drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (clr_ovf) begin
         r_ovf      <= w_drop;
         r_drop_cnt <= DROP_W'(w_drop);
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
         end
      end
   end

   assign out_data  = r_out.data;
   assign out_bytes = r_out.bytes;
   assign out_valid = r_out_valid;
   assign overflow  = r_ovf;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_arb_byte_packer.sv
// Randomized scoreboard bench for arb_byte_packer against a queue-based model.
module tb_arb_byte_packer;

   localparam int unsigned T = 8;
`ifdef PACKER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [7:0]  in_data   = '0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_ovf   = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0]  acc_q[$];
   logic [34:0] sb_q[$];
   bit          m_busy = 1'b0;
   bit          m_ovf  = 1'b0;
   int          m_drop = 0;
   int          m_idle = 0;

   arb_byte_packer #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_bytes (out_bytes),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_ovf   (clr_ovf),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      acc_q.delete();
      sb_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_idle = 0;
   endtask

   // One clock edge of the packer described as a byte FIFO feeding a one-word slot
   task automatic model_step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
      int          n0;
      bit          free;
      bit          drop;
      bit          emit;
      int          nb;
      logic [31:0] w;
      n0   = acc_q.size();
      free = !m_busy || rdy;
      drop = 1'b0;
      emit = 1'b0;
      nb   = 0;
      w    = '0;
      if (v) begin
         if (n0 == 4 && !free) drop = 1'b1;
         else acc_q.push_back(d);
      end
      if (free && acc_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) w[8*i +: 8] = acc_q.pop_front();
         nb   = 4;
         emit = 1'b1;
      end else if (TMO_EN && free && !v && n0 >= 1 && n0 <= 3 && m_idle >= T) begin
         for (int i = 0; i < n0; i++) w[8*i +: 8] = acc_q.pop_front();
         nb   = n0;
         emit = 1'b1;
      end
      if (v || n0 == 0 || n0 == 4) m_idle = 0;
      else if (m_idle < T) m_idle++;
      if (emit) sb_q.push_back({3'(nb), w});
      m_busy = emit ? 1'b1 : (m_busy && !rdy);
      if (clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      if (drop) begin
         m_ovf = 1'b1;
         if (m_drop < 255) m_drop++;
      end
   endtask

   // Check registered status after the last edge, then apply next inputs
   task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      clr_ovf   = clr;
      model_step(v, d, rdy, clr);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      clr_ovf  = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_bytes", 64'(out_bytes), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: pop expected words on each handshake, and watch held words for stability
   initial begin : monitor
      bit          hold;
      logic [31:0] hd;
      logic [2:0]  hb;
      logic [34:0] e;
      hold = 1'b0;
      hd   = '0;
      hb   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            continue;
         end
         if (hold) chk("hold_stable", {28'd0, out_valid, out_bytes, out_data},
                       {28'd0, 1'b1, hb, hd});
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_word", {29'd0, out_bytes, out_data}, 64'hDEAD);
            end else begin
               e = sb_q.pop_front();
               chk("word", {29'd0, out_bytes, out_data}, {29'd0, e});
            end
         end
         hold = out_valid && !out_ready;
         hd   = out_data;
         hb   = out_bytes;
      end
   end

   initial begin : driver
      do_reset();
      cycle(0, 8'h00, 1'b1, 1'b0);

      // four bytes with a ready consumer
      cycle(1, 8'h11, 1'b1, 1'b0);
      cycle(1, 8'h22, 1'b1, 1'b0);
      cycle(1, 8'h33, 1'b1, 1'b0);
      cycle(1, 8'h44, 1'b1, 1'b0);
      cycle(0, 8'h00, 1'b1, 1'b0);
      chk("w031_data", 64'(out_data), 64'h44332211);
      chk("w031_bytes", 64'(out_bytes), 64'd4);
      repeat (2) cycle(0, 8'h00, 1'b1, 1'b0);

      // blocked consumer: one word held, one word in the accumulator
      for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 1'b0, 1'b0);
      cycle(0, 8'h00, 1'b0, 1'b0);
      chk("w032_held", 64'(out_data), 64'h04030201);
      cycle(0, 8'h00, 1'b1, 1'b0);
      cycle(0, 8'h00, 1'b1, 1'b0);
      chk("w032_second", 64'(out_data), 64'h08070605);
      repeat (2) cycle(0, 8'h00, 1'b1, 1'b0);

      // ninth byte dropped, then cleared
      for (int i = 1; i <= 9; i++) cycle(1, 8'(8'h20 + i), 1'b0, 1'b0);
      cycle(0, 8'h00, 1'b0, 1'b0);
      chk("w033_ovf", 64'(overflow), 64'd1);
      chk("w033_drop", 64'(drop_cnt), 64'd1);
      cycle(0, 8'h00, 1'b0, 1'b1);
      cycle(0, 8'h00, 1'b0, 1'b0);
      chk("w033_clr_ovf", 64'(overflow), 64'd0);
      chk("w033_clr_drop", 64'(drop_cnt), 64'd0);

      // drop count saturates
      for (int i = 0; i < 300; i++) cycle(1, 8'(i), 1'b0, 1'b0);
      cycle(0, 8'h00, 1'b0, 1'b0);
      chk("drop_sat", 64'(drop_cnt), 64'd255);
      cycle(0, 8'h00, 1'b1, 1'b1);
      repeat (4) cycle(0, 8'h00, 1'b1, 1'b0);

      // partial word and idle cycles
      cycle(1, 8'hAA, 1'b1, 1'b0);
      cycle(1, 8'hBB, 1'b1, 1'b0);
      repeat (12) cycle(0, 8'h00, 1'b1, 1'b0);
`ifdef PACKER_TIMEOUT_EN
      chk("w034_flush_data", 64'(out_data), 64'h0000BBAA);
      chk("w034_flush_bytes", 64'(out_bytes), 64'd2);
`else
      chk("w034_no_flush", 64'(out_valid), 64'd0);
`endif

      // reset discards a partial word
      do_reset();
      cycle(1, 8'hE1, 1'b1, 1'b0);
      cycle(1, 8'hE2, 1'b1, 1'b0);
      do_reset();
      cycle(1, 8'hC1, 1'b1, 1'b0);
      cycle(1, 8'hC2, 1'b1, 1'b0);
      cycle(1, 8'hC3, 1'b1, 1'b0);
      cycle(1, 8'hC4, 1'b1, 1'b0);
      cycle(0, 8'h00, 1'b1, 1'b0);
      chk("w035_data", 64'(out_data), 64'hC4C3C2C1);
      repeat (2) cycle(0, 8'h00, 1'b1, 1'b0);

      // FULL drains while a new byte arrives the same cycle
      for (int i = 0; i < 8; i++) cycle(1, 8'(8'h60 + i), 1'b0, 1'b0);
      cycle(1, 8'h55, 1'b1, 1'b0);
      cycle(1, 8'h56, 1'b1, 1'b0);
      chk("w036_full_word", 64'(out_data), 64'h67666564);
      cycle(1, 8'h57, 1'b1, 1'b0);
      cycle(1, 8'h58, 1'b1, 1'b0);
      cycle(0, 8'h00, 1'b1, 1'b0);
      chk("w036_lane0", 64'(out_data), 64'h58575655);
      repeat (2) cycle(0, 8'h00, 1'b1, 1'b0);

      // random traffic, first with an eager then a sluggish consumer
      for (int i = 0; i < 800; i++)
         cycle(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
      for (int i = 0; i < 800; i++)
         cycle(1'($urandom_range(0, 9) < 5), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 63) == 0));

      repeat (24) cycle(0, 8'h00, 1'b1, 1'b0);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
